// File: rtl/fir_out_fmt.sv
// Output formatter behind the symmetric FIR: drops warm-up samples, rounds and saturates,
// optionally decimates, and buffers words in a first-word-fall-through FIFO.
module fir_out_fmt #(
    parameter int IN_W   = 33,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 16,
    parameter int DEC    = 1,
    parameter int WARMUP = 5,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic                    ovf_flag,
    input  logic                    clr_flags
);

    localparam int SUM_W = IN_W + 1;
    localparam int WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int DC_W  = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [WU_W-1:0]  WU_MAX   = WU_W'(WARMUP);
    localparam logic [WU_W-1:0]  WU_ONE   = WU_W'(1'b1);
    localparam logic [DC_W-1:0]  DC_MAX   = DC_W'(DEC - 1);
    localparam logic [DC_W-1:0]  DC_ONE   = DC_W'(1'b1);
    localparam logic [DC_W-1:0]  DC_ZERO  = {DC_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [SUM_W-1:0] SUM_ONE = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic signed [SUM_W-1:0] RND =
        (SHIFT > 0) ? $signed(SUM_ONE << ((SHIFT > 0) ? SHIFT - 1 : 0)) : $signed({SUM_W{1'b0}});
    localparam logic signed [SUM_W-1:0] SAT_HI = $signed({{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_LO = $signed({{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    logic                    ce_d_r;
    logic [WU_W-1:0]         wu_cnt_r;
    logic [DC_W-1:0]         dec_cnt_r;
    logic                    fmt_v_r;
    logic [OUT_W-1:0]        fmt_q_r;
    logic [OUT_W-1:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    out_valid_r;
    logic                    sat_flag_r;
    logic                    ovf_flag_r;

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] rnd_s;
    logic [OUT_W-1:0]        word_s;
    logic                    clip_s;
    logic                    warm_s;
    logic                    keep_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_ok_s;
    logic                    ovf_set_s;
    logic                    sat_set_s;
    logic [CNT_W-1:0]        count_nxt_s;

    // Round half toward +inf in one extra bit, then clip to the output range.
    always_comb begin
        sum_s  = $signed({y_in[IN_W-1], y_in}) + RND;
        rnd_s  = sum_s >>> SHIFT;
        word_s = rnd_s[OUT_W-1:0];
        clip_s = 1'b0;
        if (rnd_s > SAT_HI) begin
            word_s = SAT_HI[OUT_W-1:0];
            clip_s = 1'b1;
        end else if (rnd_s < SAT_LO) begin
            word_s = SAT_LO[OUT_W-1:0];
            clip_s = 1'b1;
        end else begin
            word_s = rnd_s[OUT_W-1:0];
            clip_s = 1'b0;
        end
    end

    // Sample qualification and FIFO bookkeeping.
    always_comb begin
        warm_s    = (wu_cnt_r == WU_MAX);
        keep_s    = ce_d_r & warm_s & (dec_cnt_r == DC_ZERO);
        sat_set_s = keep_s & clip_s;
        full_s    = (count_r == CNT_FULL);
        pop_s     = out_valid_r & out_ready;
        push_ok_s = fmt_v_r & (~full_s | pop_s);
        ovf_set_s = fmt_v_r & full_s & ~pop_s;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Sample intake: fresh-sample detect, warm-up discard, decimation, format register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ce_d_r    <= 1'b0;
            wu_cnt_r  <= {WU_W{1'b0}};
            dec_cnt_r <= DC_ZERO;
            fmt_v_r   <= 1'b0;
            fmt_q_r   <= {OUT_W{1'b0}};
        end else begin
            ce_d_r  <= ce;
            fmt_v_r <= keep_s;
            if (keep_s) begin
                fmt_q_r <= word_s;
            end else begin
                fmt_q_r <= fmt_q_r;
            end
            if (ce_d_r && !warm_s) begin
                wu_cnt_r <= wu_cnt_r + WU_ONE;
            end else begin
                wu_cnt_r <= wu_cnt_r;
            end
            if (ce_d_r && warm_s) begin
                dec_cnt_r <= (dec_cnt_r == DC_MAX) ? DC_ZERO : dec_cnt_r + DC_ONE;
            end else begin
                dec_cnt_r <= dec_cnt_r;
            end
        end
    end

    // FIFO storage and pointers; the slot freed by a pop may be refilled on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {OUT_W{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= fmt_q_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // Sticky flags; a set event on the clearing edge keeps the flag high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_flag_r <= 1'b0;
            ovf_flag_r <= 1'b0;
        end else begin
            sat_flag_r <= sat_set_s | (sat_flag_r & ~clr_flags);
            ovf_flag_r <= ovf_set_s | (ovf_flag_r & ~clr_flags);
        end
    end

    assign out_data  = $signed(mem_r[rd_ptr_r]);
    assign out_valid = out_valid_r;
    assign sat_flag  = sat_flag_r;
    assign ovf_flag  = ovf_flag_r;

endmodule
